// File: rtl/yarp_wb_writer_if.sv
// Load-response and ALU-result handshakes into the writeback writer.
// slave: the writer (accepts results); master: LSU/execute producers.
interface yarp_wb_writer_if;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_byte_off_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;

  modport slave (
    input  lsu_valid_i,
    input  lsu_rd_i,
    input  lsu_data_i,
    input  lsu_funct3_i,
    input  lsu_byte_off_i,
    input  alu_valid_i,
    input  alu_rd_i,
    input  alu_data_i,
    output lsu_ready_o,
    output alu_ready_o
  );

  modport master (
    output lsu_valid_i,
    output lsu_rd_i,
    output lsu_data_i,
    output lsu_funct3_i,
    output lsu_byte_off_i,
    output alu_valid_i,
    output alu_rd_i,
    output alu_data_i,
    input  lsu_ready_o,
    input  alu_ready_o
  );
endinterface

// File: rtl/yarp_wb_writer.sv
// Writeback writer: arbitrates LSU/ALU onto the regfile write port,
// formats loads, and scoreboards destinations with loads in flight.
// Ports: clk/reset_n, ld_issue_i/ld_rd_i (scoreboard set), bus
// (LSU/ALU handshakes), rd_addr_o/wr_en_o/wr_data_o (regfile),
// rs1/rs2/rdchk lookups with *_busy_o, sticky err_o.
module yarp_wb_writer #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_rd_i,
  yarp_wb_writer_if.slave bus,
  output logic [4:0]  rd_addr_o,
  output logic        wr_en_o,
  output logic [31:0] wr_data_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rdchk_addr_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rdchk_busy_o,
  output logic        err_o
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic                wr_en_q, wr_en_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         data_q, data_d;
  logic                src_lsu_q, src_lsu_d;
  logic                err_q, err_d;

  logic        lsu_fire, alu_fire;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;
  logic        f3_bad;

  // LSU has fixed priority and is never back-pressured.
  assign bus.lsu_ready_o = 1'b1;
  assign bus.alu_ready_o = ~bus.lsu_valid_i;
  assign lsu_fire = bus.lsu_valid_i;
  assign alu_fire = bus.alu_valid_i & ~bus.lsu_valid_i;

  assign shifted = bus.lsu_data_i >> {bus.lsu_byte_off_i, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = bus.lsu_byte_off_i[1] ? bus.lsu_data_i[31:16]
                                         : bus.lsu_data_i[15:0];

  always_comb begin
    f3_bad  = 1'b0;
    ld_data = bus.lsu_data_i;
    unique case (1'b1)
      (bus.lsu_funct3_i == F3_LB):
        ld_data = {{24{byte_v[7]}}, byte_v};
      (bus.lsu_funct3_i == F3_LH):
        ld_data = {{16{half_v[15]}}, half_v};
      (bus.lsu_funct3_i == F3_LW):
        ld_data = bus.lsu_data_i;
      (bus.lsu_funct3_i == F3_LBU):
        ld_data = {24'h0, byte_v};
      (bus.lsu_funct3_i == F3_LHU):
        ld_data = {16'h0, half_v};
      default: begin
        f3_bad  = 1'b1;
        ld_data = bus.lsu_data_i;
      end
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    src_lsu_d = 1'b0;
    if (lsu_fire) begin
      wr_en_d   = (bus.lsu_rd_i != 5'd0);
      rd_d      = bus.lsu_rd_i;
      data_d    = ld_data;
      src_lsu_d = 1'b1;
    end else if (alu_fire) begin
      wr_en_d = (bus.alu_rd_i != 5'd0);
      rd_d    = bus.alu_rd_i;
      data_d  = bus.alu_data_i;
    end
  end

  // Clear on the edge the regfile captures the load; set wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (ld_issue_i && (ld_rd_i != 5'd0))
      set_vec[ld_rd_i] = 1'b1;
    if (wr_en_q && src_lsu_q)
      clr_vec[rd_q] = 1'b1;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (lsu_fire && (bus.lsu_rd_i != 5'd0) &&
        !pending_q[bus.lsu_rd_i])
      err_d = 1'b1;
    if (ld_issue_i && pending_q[ld_rd_i])
      err_d = 1'b1;
    if (lsu_fire && f3_bad)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      src_lsu_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_en_q   <= wr_en_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      src_lsu_q <= src_lsu_d;
      err_q     <= err_d;
    end
  end

  assign rd_addr_o    = rd_q;
  assign wr_en_o      = wr_en_q;
  assign wr_data_o    = data_q;
  assign err_o        = err_q;
  assign rs1_busy_o   = pending_q[rs1_addr_i];
  assign rs2_busy_o   = pending_q[rs2_addr_i];
  assign rdchk_busy_o = pending_q[rdchk_addr_i];

endmodule
